lpc_frame_arbiter: RTL and testbench
====================================

// Module: lpc_frame_arbiter
// PURPOSE
//   Frame-level round-robin arbiter sharing one lpc_decoder between NUM_CH AXI-Stream frame sources.
//   Sits between the per-source LPC frame streams and the decoder's TDATA/TVALID/TREADY/TUSER/TLAST input.
//   A grant is held for a whole frame (until the TLAST beat is accepted); M_TID tags the source.
//   A stall watchdog releases a grant if its source stops sending mid-frame.
// PARAMETERS
//   NUM_CH    4     number of requesting sources (2..16)
//   DATA_W    80    TDATA width (one encoded LPC frame word)
//   ID_W      2     width of M_TID / ERR_CH; must be >= clog2(NUM_CH)
//   TIMEOUT   256   stall cycles (granted source TVALID low) before forced release; >= 2
// PORTS
//   ACLK         in   1              clock, all logic on rising edge
//   ARESET       in   1              synchronous reset, active-high
//   CH_EN        in   NUM_CH         per-source arbitration enable
//   S_TDATA      in   NUM_CH*DATA_W  source data, ch i at [i*DATA_W +: DATA_W]
//   S_TVALID     in   NUM_CH         source valid
//   S_TREADY     out  NUM_CH         source ready
//   S_TUSER      in   NUM_CH         source user bit
//   S_TLAST      in   NUM_CH         source end-of-frame
//   M_TDATA      out  DATA_W         to decoder TDATA
//   M_TVALID     out  1              to decoder TVALID
//   M_TREADY     in   1              from decoder TREADY
//   M_TUSER      out  1              to decoder TUSER
//   M_TLAST      out  1              to decoder TLAST
//   M_TID        out  ID_W           index of granted source
//   BUSY         out  1              1 while in GRANT state
//   TIMEOUT_ERR  out  1              one-cycle pulse on watchdog release
//   ERR_CH       out  ID_W           source index of last watchdog release (held)
// BEHAVIOUR
//   Reset: state=IDLE, grant g=0, RR pointer last=NUM_CH-1 (ch0 wins first), stall cnt=0,
//     all outputs 0 (S_TREADY=0, M_TVALID=0, M_TDATA=0, M_TID=0, BUSY=0, TIMEOUT_ERR=0, ERR_CH=0).
//   FSM IDLE: req = CH_EN & S_TVALID. If req!=0, g <= first set bit searching last+1, last+2, ... mod NUM_CH;
//     last <= g; state <= GRANT next edge. No S_TREADY asserted in IDLE (1-cycle arbitration bubble).
//   FSM GRANT: combinational pass-through, zero latency: M_TDATA/M_TVALID/M_TUSER/M_TLAST = source g;
//     S_TREADY[g]=M_TREADY, S_TREADY[others]=0; M_TID=g; BUSY=1.
//   Beat accepted when S_TVALID[g]&M_TREADY; beat with S_TLAST[g]=1 -> IDLE next edge.
//   Single-beat frame (TLAST on first beat): grant lasts exactly one accepted beat.
//   CH_EN[g] falling mid-frame does not revoke the grant; it takes effect at the next arbitration.
//   Watchdog: cnt clears on entering GRANT and on any cycle S_TVALID[g]=1; else increments (saturating).
//     When cnt reaches TIMEOUT-1 with S_TVALID[g]=0: TIMEOUT_ERR=1 for that cycle, ERR_CH<=g, IDLE next edge.
//     Truncated frame is not patched; downstream sees no TLAST (decoder resync is its own concern).
//   Backpressure (M_TVALID=1, M_TREADY=0) is not a stall; cnt stays 0.
//   M_TDATA/M_TUSER/M_TLAST driven 0 in IDLE; M_TID holds g.
//   ARESET mid-frame: grant dropped immediately at that edge, pointer back to NUM_CH-1.
//   No source starved: each frame completion rotates priority past g.
// TESTING
//   1. Reset, ch0 and ch2 send 3-beat frames together -> ch0 frame (M_TID=0) then 1 bubble then ch2 (M_TID=2),
//      no interleaved beats.
//   2. All 4 sources continuously valid, 1-beat frames -> grant order 0,1,2,3,0 with M_TLAST each.
//   3. Granted ch1 drops TVALID after beat 1, TIMEOUT=8 -> TIMEOUT_ERR pulse 8 cycles later, ERR_CH=1,
//      next grant goes to ch2.
//   4. M_TREADY held low 500 cycles mid-frame with TIMEOUT=256 -> no TIMEOUT_ERR, data held stable, frame completes.
//   5. CH_EN=4'b0101, all valid -> only ch0/ch2 granted; CH_EN[0] cleared mid ch0 frame -> frame still completes.
//   6. ARESET asserted on beat 2 of a ch3 frame -> next cycle S_TREADY=0, BUSY=0; first post-reset grant is ch0.

Source files
------------

// File: rtl/lpc_frame_arbiter.sv
// Frame-level round-robin arbiter feeding one lpc_decoder from NUM_CH streams.
// Grant is held until the TLAST beat is accepted or the stall watchdog fires.
module lpc_frame_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 80,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NUM_CH-1:0]        CH_EN,
  input  logic [NUM_CH*DATA_W-1:0] S_TDATA,
  input  logic [NUM_CH-1:0]        S_TVALID,
  output logic [NUM_CH-1:0]        S_TREADY,
  input  logic [NUM_CH-1:0]        S_TUSER,
  input  logic [NUM_CH-1:0]        S_TLAST,
  output logic [DATA_W-1:0]        M_TDATA,
  output logic                     M_TVALID,
  input  logic                     M_TREADY,
  output logic                     M_TUSER,
  output logic                     M_TLAST,
  output logic [ID_W-1:0]          M_TID,
  output logic                     BUSY,
  output logic                     TIMEOUT_ERR,
  output logic [ID_W-1:0]          ERR_CH
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   g;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   err_ch;
  logic [CW-1:0]     cnt;
  logic [NUM_CH-1:0] req;
  logic              found;
  logic              vg;
  logic              stall_hit;

  assign req       = CH_EN & S_TVALID;
  assign vg        = S_TVALID[g];
  assign stall_hit = (state == GRANT) && !vg
                     && (cnt == CW'(TIMEOUT - 1));

  // Search starts one past the last winner so every source gets a turn.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = ID_W'((int'(last) + k) % NUM_CH);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= IDLE;
      g      <= '0;
      last   <= ID_W'(NUM_CH - 1);
      cnt    <= '0;
      err_ch <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (found) begin
            g     <= pick;
            last  <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (vg)
            cnt <= '0;
          else if (cnt != CW'(TIMEOUT - 1))
            cnt <= cnt + 1'b1;
          if (vg && M_TREADY && S_TLAST[g]) begin
            state <= IDLE;
          end else if (stall_hit) begin
            err_ch <= g;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    M_TDATA  = '0;
    M_TVALID = 1'b0;
    M_TUSER  = 1'b0;
    M_TLAST  = 1'b0;
    S_TREADY = '0;
    if (state == GRANT) begin
      M_TDATA     = S_TDATA[g*DATA_W +: DATA_W];
      M_TVALID    = vg;
      M_TUSER     = S_TUSER[g];
      M_TLAST     = S_TLAST[g];
      S_TREADY[g] = M_TREADY;
    end
  end

  assign M_TID       = g;
  assign BUSY        = (state == GRANT);
  assign TIMEOUT_ERR = stall_hit;
  assign ERR_CH      = err_ch;

endmodule

// File: tb/tb_lpc_frame_arbiter.sv
// Directed bench for lpc_frame_arbiter: per-source frame generators
// drive the inputs, accepted output beats are logged and checked.
module tb_lpc_frame_arbiter;

  localparam int N  = 4;
  localparam int DW = 80;
  localparam int IW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          areset;
  logic [N-1:0]  ch_en;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tready;
  logic [N-1:0]  s_tuser;
  logic [N-1:0]  s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tuser;
  logic          m_tlast;
  logic [IW-1:0] m_tid;
  logic          busy;
  logic          timeout_err;
  logic [IW-1:0] err_ch;

  always #5 clk = ~clk;

  lpc_frame_arbiter #(
    .NUM_CH(N), .DATA_W(DW), .ID_W(IW), .TIMEOUT(TO)
  ) dut (
    .ACLK(clk), .ARESET(areset), .CH_EN(ch_en),
    .S_TDATA(s_tdata), .S_TVALID(s_tvalid), .S_TREADY(s_tready),
    .S_TUSER(s_tuser), .S_TLAST(s_tlast),
    .M_TDATA(m_tdata), .M_TVALID(m_tvalid), .M_TREADY(m_tready),
    .M_TUSER(m_tuser), .M_TLAST(m_tlast), .M_TID(m_tid),
    .BUSY(busy), .TIMEOUT_ERR(timeout_err), .ERR_CH(err_ch)
  );

  int nfr[N];
  int len[N];
  int beat[N];
  int stopat[N];
  int ntest = 0;
  int nfail = 0;
  int cyc_n = 0;
  int tout_n;
  int stall_n;
  int tout_stall;
  int lg_tid[$];
  int lg_last[$];
  int lg_beat[$];
  int lg_ch[$];
  int lg_user[$];
  int lg_cyc[$];

  logic [DW-1:0] sn_data;
  logic          sn_valid;
  logic          sn_busy;
  logic [N-1:0]  sn_sready;
  logic [IW-1:0] sn_tid;
  logic          sn_tout;
  logic [IW-1:0] sn_errch;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i] = (nfr[i] > 0) && (beat[i] != stopat[i]);
      s_tlast[i]  = (beat[i] == len[i] - 1);
      s_tuser[i]  = (beat[i] == 0);
      s_tdata[i*DW +: DW] = {64'h0, 8'(i), 8'(beat[i])};
    end
  endtask

  task automatic cyc();
    logic [N-1:0] acc;
    @(negedge clk);
    acc       = s_tvalid & s_tready;
    sn_data   = m_tdata;
    sn_valid  = m_tvalid;
    sn_busy   = busy;
    sn_sready = s_tready;
    sn_tid    = m_tid;
    sn_tout   = timeout_err;
    sn_errch  = err_ch;
    if (busy && !s_tvalid[m_tid]) stall_n++;
    if (timeout_err) begin
      tout_n++;
      tout_stall = stall_n;
    end
    if (m_tvalid && m_tready) begin
      lg_tid.push_back(int'(m_tid));
      lg_last.push_back(int'(m_tlast));
      lg_beat.push_back(int'(m_tdata[7:0]));
      lg_ch.push_back(int'(m_tdata[15:8]));
      lg_user.push_back(int'(m_tuser));
      lg_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          nfr[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive_src();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic run_until_log(input string tag, input int k,
                               input int max);
    int c;
    c = 0;
    while (lg_tid.size() < k && c < max) begin
      cyc();
      c++;
    end
    check({tag, "_wait"}, lg_tid.size(), k);
  endtask

  task automatic clear_log();
    lg_tid.delete();
    lg_last.delete();
    lg_beat.delete();
    lg_ch.delete();
    lg_user.delete();
    lg_cyc.delete();
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    m_tready = 1'b1;
    ch_en    = 4'hF;
    for (int i = 0; i < N; i++) begin
      nfr[i]    = 0;
      len[i]    = 1;
      beat[i]   = 0;
      stopat[i] = -1;
    end
    drive_src();
    run(2);
    areset  = 1'b0;
    clear_log();
    tout_n  = 0;
    stall_n = 0;
  endtask

  initial begin
    int bad;
    areset     = 1'b1;
    m_tready   = 1'b0;
    ch_en      = '0;
    tout_stall = 0;
    for (int i = 0; i < N; i++) begin
      nfr[i] = 0; len[i] = 1; beat[i] = 0; stopat[i] = -1;
    end
    drive_src();

    // reset state
    do_reset();
    check("rst_sready", 32'(sn_sready), 0);
    check("rst_mvalid", 32'(sn_valid), 0);
    check("rst_mdata", sn_data[31:0], 0);
    check("rst_tid", 32'(sn_tid), 0);
    check("rst_busy", 32'(sn_busy), 0);
    check("rst_tout", 32'(sn_tout), 0);
    check("rst_errch", 32'(sn_errch), 0);

    // 1: ch0 and ch2 send 3-beat frames together
    nfr[0] = 1; len[0] = 3;
    nfr[2] = 1; len[2] = 3;
    drive_src();
    run(12);
    check("t1_n", lg_tid.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_tid%0d", i), lg_tid[i], (i < 3) ? 0 : 2);
      check($sformatf("t1_beat%0d", i), lg_beat[i], i % 3);
      check($sformatf("t1_last%0d", i), lg_last[i],
            (i % 3 == 2) ? 1 : 0);
      check($sformatf("t1_ch%0d", i), lg_ch[i], lg_tid[i]);
    end
    check("t1_user0", lg_user[0], 1);
    check("t1_user1", lg_user[1], 0);
    check("t1_bubble", lg_cyc[3] - lg_cyc[2], 2);
    check("t1_idle_tid", 32'(sn_tid), 2);
    check("t1_idle_busy", 32'(sn_busy), 0);
    check("t1_idle_data", sn_data[31:0], 0);

    // 2: all sources valid, 1-beat frames
    do_reset();
    for (int i = 0; i < N; i++) begin
      nfr[i] = 2; len[i] = 1;
    end
    drive_src();
    run(20);
    check("t2_n", lg_tid.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_tid%0d", i), lg_tid[i], i % 4);
      check($sformatf("t2_last%0d", i), lg_last[i], 1);
    end

    // 3: granted ch1 stalls after beat 0
    do_reset();
    nfr[1] = 1; len[1] = 4; stopat[1] = 1;
    nfr[2] = 1; len[2] = 1;
    drive_src();
    run(20);
    check("t3_tout_n", tout_n, 1);
    check("t3_stall", tout_stall, TO);
    check("t3_errch", 32'(err_ch), 1);
    check("t3_n", lg_tid.size(), 2);
    check("t3_tid0", lg_tid[0], 1);
    check("t3_tid1", lg_tid[1], 2);
    check("t3_last0", lg_last[0], 0);

    // 4: long backpressure mid-frame is not a stall
    do_reset();
    nfr[0] = 1; len[0] = 3;
    drive_src();
    run_until_log("t4", 1, 10);
    m_tready = 1'b0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (sn_data[31:0] !== 32'h1 || !sn_valid || !sn_busy) bad++;
    end
    check("t4_hold_bad", bad, 0);
    check("t4_tout", tout_n, 0);
    check("t4_n_hold", lg_tid.size(), 1);
    m_tready = 1'b1;
    run(5);
    check("t4_n", lg_tid.size(), 3);
    check("t4_beat1", lg_beat[1], 1);
    check("t4_last2", lg_last[2], 1);
    check("t4_tout_end", tout_n, 0);

    // 5: CH_EN masks ch1/ch3; ch0 disabled mid-frame
    do_reset();
    ch_en = 4'b0101;
    for (int i = 0; i < N; i++) begin
      nfr[i] = 2; len[i] = 2;
    end
    drive_src();
    run_until_log("t5", 1, 10);
    ch_en = 4'b0100;
    run(20);
    check("t5_n", lg_tid.size(), 6);
    check("t5_tid0", lg_tid[0], 0);
    check("t5_tid1", lg_tid[1], 0);
    check("t5_last1", lg_last[1], 1);
    for (int i = 2; i < 6; i++)
      check($sformatf("t5_tid%0d", i), lg_tid[i], 2);

    // 6: reset mid ch3 frame
    do_reset();
    nfr[3] = 1; len[3] = 4;
    drive_src();
    run_until_log("t6", 2, 10);
    check("t6_pre_tid", 32'(m_tid), 3);
    areset = 1'b1;
    run(2);
    check("t6_sready", 32'(sn_sready), 0);
    check("t6_busy", 32'(sn_busy), 0);
    check("t6_tid", 32'(sn_tid), 0);
    areset = 1'b0;
    nfr[0] = 1; len[0] = 1;
    drive_src();
    clear_log();
    run_until_log("t6_post", 1, 10);
    check("t6_first", lg_tid[0], 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
